// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - 32x32 register file with write-back bypass and issue scoreboard
//
// Purpose: holds the architectural integer registers, forwards same-cycle
// write-back data to the read ports, and tracks registers with writes in
// flight so decode can be stalled on RAW/WAW hazards.
//
// Ports:
//   clk             - single clock, all state on rising edge
//   reset           - synchronous active-high reset
//   rs1_addr/rs2_addr - source register read addresses from decode
//   rs1_data/rs2_data - combinational read data (with write-back bypass)
//   issue_valid     - decode presents an instruction this cycle
//   issue_reg_write - issuing instruction writes a destination register
//   issue_rd        - destination register of the issuing instruction
//   wb_reg_write    - write-back commits a register write this cycle
//   wb_rd / wb_data - write-back destination and data
//   stall           - issue blocked by a hazard this cycle
//   busy_mask       - registered scoreboard, bit n = register n pending
//   stall_count     - saturating count of stalled cycles
module reg_file_scoreboard (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        issue_valid,
    input  logic        issue_reg_write,
    input  logic [4:0]  issue_rd,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        stall,
    output logic [31:0] busy_mask,
    output logic [15:0] stall_count
);

    logic [31:0] regs_q [32];
    logic [31:0] busy_q;
    logic [31:0] busy_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    logic        wb_en;
    logic        stall_c;
    logic        accept;
    logic [31:0] clear_vec;
    logic [31:0] set_vec;
    logic [31:0] pending;

    assign wb_en     = wb_reg_write & (wb_rd != 5'd0);
    assign clear_vec = wb_en ? (32'd1 << wb_rd) : 32'd0;

    // A register being written back this cycle no longer counts as a hazard,
    // so the dependent instruction can issue in the same cycle via bypass.
    assign pending = busy_q & ~clear_vec;

    // Gated by reset so a stale scoreboard cannot stall during reset cycles.
    assign stall_c = ~reset & issue_valid &
                     (pending[rs1_addr] | pending[rs2_addr] |
                      (issue_reg_write & pending[issue_rd]));

    assign accept  = issue_valid & ~stall_c & issue_reg_write & (issue_rd != 5'd0);
    assign set_vec = accept ? (32'd1 << issue_rd) : 32'd0;

    // Set is OR'd after the clear so a new issue wins over a same-edge write-back.
    assign busy_d = pending | set_vec;
    assign cnt_d  = (stall_c && (cnt_q != 16'hFFFF)) ? (cnt_q + 16'd1) : cnt_q;

    always_comb begin
        rs1_data = regs_q[rs1_addr];
        if (wb_en && (wb_rd == rs1_addr)) begin
            rs1_data = wb_data;
        end
        if (rs1_addr == 5'd0) begin
            rs1_data = 32'd0;
        end
    end

    always_comb begin
        rs2_data = regs_q[rs2_addr];
        if (wb_en && (wb_rd == rs2_addr)) begin
            rs2_data = wb_data;
        end
        if (rs2_addr == 5'd0) begin
            rs2_data = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
            busy_q <= 32'd0;
            cnt_q  <= 16'd0;
        end else begin
            if (wb_en) begin
                regs_q[wb_rd] <= wb_data;
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign stall       = stall_c;
    assign busy_mask   = busy_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb/tb_reg_file_scoreboard.sv - randomized and directed bench for reg_file_scoreboard
module tb_reg_file_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        issue_valid, issue_reg_write;
    logic [4:0]  issue_rd;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic [31:0] busy_mask;
    logic [15:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: architectural state as plain arrays and an integer counter.
    logic [31:0] m_reg [32];
    bit          m_busy [32];
    int          m_cnt;

    reg_file_scoreboard dut (
        .clk             (clk),
        .reset           (reset),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .issue_valid     (issue_valid),
        .issue_reg_write (issue_reg_write),
        .issue_rd        (issue_rd),
        .wb_reg_write    (wb_reg_write),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .stall           (stall),
        .busy_mask       (busy_mask),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (wb_reg_write && wb_rd == a) return wb_data;
        return m_reg[a];
    endfunction

    function automatic bit m_pending(input logic [4:0] n);
        return m_busy[n] && !(wb_reg_write && wb_rd == n && n != 0);
    endfunction

    function automatic bit m_stall();
        if (reset || !issue_valid) return 1'b0;
        return m_pending(rs1_addr) || m_pending(rs2_addr) ||
               (issue_reg_write && m_pending(issue_rd));
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // Entered just after a falling edge with inputs already driven.
    task automatic step();
        bit st;
        #1;
        st = m_stall();
        check("rs1_data", rs1_data, m_read(rs1_addr));
        check("rs2_data", rs2_data, m_read(rs2_addr));
        check("stall", {31'd0, stall}, {31'd0, st});
        check("busy_mask", busy_mask, m_mask());
        check("stall_count", {16'd0, stall_count}, m_cnt[31:0]);
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i] = 0;
                m_busy[i] = 0;
            end
            m_cnt = 0;
        end else begin
            if (wb_reg_write && wb_rd != 0) begin
                m_reg[wb_rd] = wb_data;
                m_busy[wb_rd] = 0;
            end
            if (issue_valid && !st && issue_reg_write && issue_rd != 0) m_busy[issue_rd] = 1;
            if (st && m_cnt < 65535) m_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 0; issue_valid = 0; issue_reg_write = 0; issue_rd = 0;
        wb_reg_write = 0; wb_rd = 0; wb_data = 0; rs1_addr = 0; rs2_addr = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        step();
        reset = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = 0;
            m_busy[i] = 0;
        end
        m_cnt = 0;
        idle();
        reset = 1;
        @(negedge clk);
        // First reset edge: outputs before it are unknown, so skip checks here.
        @(posedge clk);
        @(negedge clk);
        idle();
        #1;
        check("reset_busy", busy_mask, 32'd0);
        check("reset_cnt", {16'd0, stall_count}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);

        // Write 5 then read it back
        wb_reg_write = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
        step();
        idle(); rs1_addr = 5;
        #1;
        check("wb5_rs1", rs1_data, 32'hDEADBEEF);
        check("wb5_busy", busy_mask, 32'd0);
        step();

        // RAW stall on rd=3, resolved by write-back bypass
        do_reset();
        idle(); issue_valid = 1; issue_reg_write = 1; issue_rd = 3;
        step();
        idle(); issue_valid = 1; rs2_addr = 3;
        #1;
        check("raw3_stall", {31'd0, stall}, 32'd1);
        step();
        step();
        wb_reg_write = 1; wb_rd = 3; wb_data = 32'h12;
        #1;
        check("raw3_cnt", {16'd0, stall_count}, 32'd2);
        check("raw3_release", {31'd0, stall}, 32'd0);
        check("raw3_bypass", rs2_data, 32'h12);
        step();

        // Same-edge issue and write-back to 7: new issue wins
        idle(); issue_valid = 1; issue_reg_write = 1; issue_rd = 7;
        step();
        issue_valid = 1; issue_reg_write = 1; issue_rd = 7;
        wb_reg_write = 1; wb_rd = 7; wb_data = 32'h77;
        #1;
        check("waw7_stall", {31'd0, stall}, 32'd0);
        step();
        idle();
        #1;
        check("waw7_busy", {31'd0, busy_mask[7]}, 32'd1);
        step();

        // Register 0 is hardwired
        idle(); wb_reg_write = 1; wb_rd = 0; wb_data = 32'hFFFFFFFF;
        issue_valid = 1; issue_reg_write = 1; issue_rd = 0;
        #1;
        check("r0_rs1", rs1_data, 32'd0);
        check("r0_stall", {31'd0, stall}, 32'd0);
        step();
        idle();
        #1;
        check("r0_busy", {31'd0, busy_mask[0]}, 32'd0);
        check("r0_read", rs1_data, 32'd0);
        step();

        // Randomized traffic, addresses kept small to provoke hazards
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset           = ($urandom_range(0, 99) == 0);
            rs1_addr        = 5'($urandom_range(0, 7));
            rs2_addr        = 5'($urandom_range(0, 7));
            issue_valid     = ($urandom_range(0, 3) != 0);
            issue_reg_write = ($urandom_range(0, 3) != 0);
            issue_rd        = 5'($urandom_range(0, 7));
            wb_reg_write    = ($urandom_range(0, 2) == 0);
            wb_rd           = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            wb_data         = $urandom;
            step();
        end

        // Long RAW stall saturates the counter, then reset mid-stall
        do_reset();
        idle(); wb_reg_write = 1; wb_rd = 4; wb_data = 32'hA5;
        issue_valid = 1; issue_reg_write = 1; issue_rd = 9;
        step();
        idle(); issue_valid = 1; rs1_addr = 9;
        for (int n = 0; n < 65600; n++) step();
        #1;
        check("sat_cnt", {16'd0, stall_count}, 32'h0000FFFF);
        check("sat_stall", {31'd0, stall}, 32'd1);
        reset = 1;
        #1;
        check("reset_stall_low", {31'd0, stall}, 32'd0);
        step();
        idle(); rs1_addr = 4; rs2_addr = 9;
        #1;
        check("post_reset_cnt", {16'd0, stall_count}, 32'd0);
        check("post_reset_busy", busy_mask, 32'd0);
        check("post_reset_r4", rs1_data, 32'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_file_scoreboard.md
REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port rs1_addr  input  5  source register 1 read address from decode.
REQ-004 SHALL have port rs2_addr  input  5  source register 2 read address from decode.
REQ-005 SHALL have port rs1_data  output  32  read data for rs1_addr.
REQ-006 SHALL have port rs2_data  output  32  read data for rs2_addr.
REQ-007 SHALL have port issue_valid  input  1  decode presents an instruction for issue this cycle.
REQ-008 SHALL have port issue_reg_write  input  1  issuing instruction will write a destination register.
REQ-009 SHALL have port issue_rd  input  5  destination register of issuing instruction.
REQ-010 SHALL have port wb_reg_write  input  1  write-back stage commits a register write this cycle.
REQ-011 SHALL have port wb_rd  input  5  write-back destination register.
REQ-012 SHALL have port wb_data  input  32  write-back data.
REQ-013 SHALL have port stall  output  1  issue blocked this cycle by hazard.
REQ-014 SHALL have port busy_mask  output  32  registered scoreboard; bit n set = register n has a pending write.
REQ-015 SHALL have port stall_count  output  16  saturating count of stalled cycles.

Function
REQ-016 SHALL hold 32 x 32-bit registers; register 0 reads 0, is never written, never marked busy.
REQ-017 SHALL write wb_data to wb_rd on rising clk when wb_reg_write=1, wb_rd!=0, reset=0.
REQ-018 SHALL read rs1_data/rs2_data combinationally (zero-cycle latency) from the array.
REQ-019 SHALL bypass: if wb_reg_write=1 and wb_rd==rsN_addr!=0 in same cycle, rsN_data = wb_data.
REQ-020 SHALL define clearing(n) = wb_reg_write & (wb_rd==n) & (n!=0) in the current cycle.
REQ-021 SHALL define pending(n) = busy_mask[n] & ~clearing(n).
REQ-022 SHALL assert stall combinationally = issue_valid & (pending(rs1_addr) | pending(rs2_addr) | (issue_reg_write & pending(issue_rd))) -- RAW on either source, WAW on destination.
REQ-023 SHALL accept issue when issue_valid=1 and stall=0; if issue_reg_write=1 and issue_rd!=0, set busy_mask[issue_rd] on that rising edge.
REQ-024 SHALL clear busy_mask[wb_rd] on rising edge when wb_reg_write=1 and wb_rd!=0.
REQ-025 SHALL, when set (REQ-023) and clear (REQ-024) target same register same edge, leave bit set (new issue wins).
REQ-026 SHALL not change busy_mask on a stalled or invalid issue.
REQ-027 SHALL increment stall_count by 1 each rising edge with stall=1; saturate at 16'hFFFF (no wrap).
REQ-028 SHALL accept wb writes to non-busy registers (array updated, busy_mask unchanged).

Reset
REQ-029 SHALL, on rising clk with reset=1, clear all 32 registers to 0, busy_mask to 0, stall_count to 0.
REQ-030 SHALL give reset priority over simultaneous issue and write-back in same cycle; both are discarded.
REQ-031 SHALL drive stall=0 during reset cycles (busy_mask=0 after first reset edge).

Verification
REQ-032 Reset then wb_reg_write=1, wb_rd=5, wb_data=32'hDEADBEEF; next cycle rs1_addr=5 -> rs1_data=32'hDEADBEEF, busy_mask=0.
REQ-033 Issue rd=3 (valid, reg_write); next cycle issue rs2_addr=3 -> stall=1, stall_count increments each cycle; wb_rd=3 data=32'h12 -> stall=0 same cycle, rs2_data=32'h12 (bypass).
REQ-034 Same-edge issue rd=7 and wb_rd=7 with busy_mask[7]=1 -> issue accepted (stall=0), busy_mask[7]=1 after edge.
REQ-035 Write to register 0 with wb_data=32'hFFFFFFFF and issue rd=0 -> rs1_data for addr 0 = 0, busy_mask[0]=0, no stall.
REQ-036 Hold RAW stall for 70000 cycles -> stall_count stops at 16'hFFFF; assert reset mid-stall -> stall_count=0, busy_mask=0, register contents 0 next cycle.
